// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg
//   Shared definitions for the two-way set-associative data cache:
//   controller state encoding, associativity and a ceil(log2) helper used to
//   derive field widths from the cache geometry parameters.
// -----------------------------------------------------------------------------
package dcache_pkg;

  localparam int WAYS = 2;

  typedef enum logic [2:0] {
    IDLE,
    MISS,
    WRITEBACK,
    REFILL,
    REFILL_DONE
  } state_t;

  // ceil(log2(value)); used only on constant geometry parameters.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dcache_way_array.sv
// -----------------------------------------------------------------------------
// dcache_way_array
//   Storage for one way of the cache: tag, valid, dirty and line data per set.
//   Reads are asynchronous at idx. Writes are synchronous: either a full-line
//   fill (tag written, valid=1, dirty=0) or a single-word store (dirty=1).
//   A fill has priority over a store at the same edge.
// Ports
//   clk_i, rst_i   clock, asynchronous active-low reset
//   idx            set index for both read and write
//   rd_tag/rd_valid/rd_dirty/rd_line  contents of set idx
//   word_we, word_sel, word_data      single-word store into set idx
//   fill_we, fill_tag, fill_line      full-line fill into set idx
// -----------------------------------------------------------------------------
module dcache_way_array
  import dcache_pkg::*;
#(
  parameter int SETS   = 32,
  parameter int TAG_W  = 22,
  parameter int LINE_W = 256,
  parameter int WORD_W = 32,
  localparam int IDX_W = clog2(SETS),
  localparam int SEL_W = clog2(LINE_W / WORD_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  idx,
  output logic [TAG_W-1:0]  rd_tag,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [LINE_W-1:0] rd_line,
  input  logic              word_we,
  input  logic [SEL_W-1:0]  word_sel,
  input  logic [WORD_W-1:0] word_data,
  input  logic              fill_we,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_line
);

  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [LINE_W-1:0] data_mem [SETS];
  logic [SETS-1:0]   valid;
  logic [SETS-1:0]   dirty;

  assign rd_tag   = tag_mem[idx];
  assign rd_line  = data_mem[idx];
  assign rd_valid = valid[idx];
  assign rd_dirty = dirty[idx];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_we) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (word_we) begin
      dirty[idx] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays are not reset; valid qualifies them, and a reset
  // port on a RAM prevents mapping it to memory macros.
  always_ff @(posedge clk_i) begin
    if (fill_we) begin
      tag_mem[idx]  <= fill_tag;
      data_mem[idx] <= fill_line;
    end else if (word_we) begin
      data_mem[idx][word_sel*WORD_W +: WORD_W] <= word_data;
    end
  end

endmodule

// File: rtl/dcache_2way_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_2way_ctrl
//   Two-way set-associative, write-back, write-allocate data cache between the
//   CPU pipeline (p1_*) and a line-wide memory (mem_*). Hits complete in the
//   request cycle; misses optionally write back a dirty victim, refill the
//   line, then replay the request as an ordinary hit.
// Ports
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   p1_addr_i, p1_data_i         CPU byte address (word aligned), store data
//   p1_MemRead_i, p1_MemWrite_i  load / store request (mutually exclusive)
//   p1_data_o, p1_stall_o        load data, request-not-yet-serviced
//   mem_data_i, mem_ack_i        refill line, one-cycle completion pulse
//   mem_data_o, mem_addr_o       write-back line, line address
//   mem_enable_o, mem_write_o    memory request, 1=write-back / 0=refill
//   hit_cnt_o, miss_cnt_o, wb_cnt_o  saturating event counters, present only
//                                    when DCACHE_PERF_CNT_EN is defined
// -----------------------------------------------------------------------------
module dcache_2way_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [WORD_W-1:0] p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [WORD_W-1:0] p1_data_o,
  output logic              p1_stall_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o,
  output logic [31:0]       wb_cnt_o
`endif
);

  localparam int OFF_W  = clog2(LINE_W / 8);
  localparam int IDX_W  = clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WOFF_W = clog2(WORD_W / 8);
  localparam int SEL_W  = OFF_W - WOFF_W;

  state_t state, next_state;

  logic              req;
  logic [ADDR_W-1:0] miss_addr;
  logic [ADDR_W-1:0] cur_addr;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [SEL_W-1:0]  sel;
  logic              unused_bits;

  logic [TAG_W-1:0]  way_tag  [WAYS];
  logic [LINE_W-1:0] way_line [WAYS];
  logic [WAYS-1:0]   way_valid, way_dirty, way_hit;
  logic [WAYS-1:0]   word_we, fill_we;

  logic              hit, hit_way, idle_hit;
  logic [LINE_W-1:0] hit_line;
  logic              victim_now, victim;
  logic [SETS-1:0]   lru;
  logic              store, fill;

  assign req = p1_MemRead_i | p1_MemWrite_i;

  // Outside IDLE the request may be dropped, so the arrays are addressed by
  // the latched miss address until the fill has completed.
  assign cur_addr    = (state == IDLE) ? p1_addr_i : miss_addr;
  assign idx         = cur_addr[OFF_W +: IDX_W];
  assign tag         = cur_addr[ADDR_W-1 -: TAG_W];
  assign sel         = cur_addr[WOFF_W +: SEL_W];
  assign unused_bits = ^cur_addr[WOFF_W-1:0];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    dcache_way_array #(
      .SETS   (SETS),
      .TAG_W  (TAG_W),
      .LINE_W (LINE_W),
      .WORD_W (WORD_W)
    ) u_way (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .idx       (idx),
      .rd_tag    (way_tag[w]),
      .rd_valid  (way_valid[w]),
      .rd_dirty  (way_dirty[w]),
      .rd_line   (way_line[w]),
      .word_we   (word_we[w]),
      .word_sel  (sel),
      .word_data (p1_data_i),
      .fill_we   (fill_we[w]),
      .fill_tag  (tag),
      .fill_line (mem_data_i)
    );

    assign way_hit[w] = way_valid[w] && (way_tag[w] == tag);
    assign word_we[w] = store && way_hit[w];
    assign fill_we[w] = fill && (victim == 1'(w));
  end

  // At most one way can hit, so the way number is just the way-1 hit bit.
  assign hit      = |way_hit;
  assign hit_way  = way_hit[1];
  assign hit_line = way_line[hit_way];
  assign idle_hit = (state == IDLE) && req && hit;

  assign p1_data_o  = hit ? hit_line[sel*WORD_W +: WORD_W] : '0;
  assign p1_stall_o = req && !idle_hit;

  // Fill an empty way first (way0 preferred); otherwise evict the LRU way.
  assign victim_now = !way_valid[0] ? 1'b0 :
                      !way_valid[1] ? 1'b1 : lru[idx];

  assign mem_addr_o = (state == WRITEBACK) ? {way_tag[victim], idx, {OFF_W{1'b0}}}
                                           : miss_addr;
  assign mem_data_o = way_line[victim];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      victim       <= 1'b0;
      miss_addr    <= '0;
      lru          <= '0;
    end else begin
      state        <= next_state;
      // Registered from next_state so enable stays high across the
      // WRITEBACK->REFILL hand-off and drops the cycle after the final ack.
      mem_enable_o <= (next_state == WRITEBACK) || (next_state == REFILL);
      mem_write_o  <= (next_state == WRITEBACK);
      if (state == MISS) victim <= victim_now;
      if ((state == IDLE) && req && !hit)
        miss_addr <= {p1_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      if (idle_hit) lru[idx] <= !hit_way;
    end
  end

  // NOTE: every output of this block is assigned a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    store      = 1'b0;
    fill       = 1'b0;
    unique case (state)
      IDLE: begin
        if (req && !hit)   next_state = MISS;
        else if (idle_hit) store      = p1_MemWrite_i;
      end
      MISS:
        next_state = (way_valid[victim_now] && way_dirty[victim_now]) ? WRITEBACK
                                                                     : REFILL;
      WRITEBACK:
        if (mem_ack_i) next_state = REFILL;
      REFILL:
        if (mem_ack_i) begin
          next_state = REFILL_DONE;
          fill       = 1'b1;
        end
      REFILL_DONE:
        next_state = IDLE;
      default:
        next_state = IDLE;
    endcase
  end

`ifdef DCACHE_PERF_CNT_EN
  logic replay;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      replay     <= 1'b0;
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
      wb_cnt_o   <= '0;
    end else begin
      // The IDLE cycle right after REFILL_DONE completes the missed request;
      // it was already counted as a miss.
      replay <= (state == REFILL_DONE);
      if (idle_hit && !replay && (hit_cnt_o != '1))
        hit_cnt_o <= hit_cnt_o + 32'd1;
      if ((state == IDLE) && req && !hit && (miss_cnt_o != '1))
        miss_cnt_o <= miss_cnt_o + 32'd1;
      if ((state == MISS) && (next_state == WRITEBACK) && (wb_cnt_o != '1))
        wb_cnt_o <= wb_cnt_o + 32'd1;
    end
  end
`else
  // Event counters are not built in this configuration.
`endif

endmodule
